// File: rtl/MSX.sv
// Shared firmware-store types and constants for the MSX slot subsystem.
package MSX;

  // One firmware-store descriptor as produced by the firmware-config parser.
  typedef struct packed {
    logic [7:0]  block_count;       // image size in blocks, 0 = entry empty
    logic [27:0] store_address;     // DDR3 staging byte address
    logic [7:0]  sram_block_count;  // consumed by the SRAM allocator only
  } fw_rom_t;

  localparam int unsigned FW_BLOCK_SHIFT = 14;
  localparam logic [26:0] FW_RAM_BASE    = 27'h0100000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_NEXT,
    ST_DONE
  } fw_load_state_t;

endpackage

// File: rtl/ddr3_byte_reader.sv
// Single-byte DDR3 read handshake: issues a one-cycle rd strobe while the
// port is idle and flags the first idle cycle afterwards as data-valid.
module ddr3_byte_reader #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  output logic              issue,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] ddr3_addr,
  output logic              ddr3_rd,
  input  logic              ddr3_ready,
  input  logic [DATA_W-1:0] ddr3_dout
);

  logic pending;

  assign issue = start && !pending && ddr3_ready && !ddr3_rd;
  assign valid = pending && ddr3_ready && !ddr3_rd;
  assign data  = ddr3_dout;

  // Strobe/address register and outstanding-read flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending   <= 1'b0;
      ddr3_rd   <= 1'b0;
      ddr3_addr <= '0;
    end else begin
      ddr3_rd <= issue;
      if (issue) begin
        ddr3_addr <= addr;
        pending   <= 1'b1;
      end else if (valid) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fw_rom_loader.sv
// Copies every populated firmware image from DDR3 staging into slot RAM on
// each update request and publishes the per-entry RAM base addresses.
module fw_rom_loader
  import MSX::*;
#(
  parameter int unsigned MAX_FW_ROM  = 8,
  parameter logic [26:0] RAM_BASE    = FW_RAM_BASE,
  parameter int unsigned BLOCK_SHIFT = FW_BLOCK_SHIFT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  update_request,
  output logic                  update_ack,
  input  fw_rom_t               fw_store [MAX_FW_ROM],
  output logic [27:0]           ddr3_addr,
  output logic                  ddr3_rd,
  output logic                  ddr3_request,
  input  logic                  ddr3_ready,
  input  logic [7:0]            ddr3_dout,
  output logic [26:0]           ram_addr,
  output logic [7:0]            ram_din,
  output logic                  ram_we,
  input  logic                  ram_ready,
  output logic [26:0]           fw_ram_base [MAX_FW_ROM],
  output logic [MAX_FW_ROM-1:0] fw_ram_valid,
  output logic                  busy
);

  localparam int unsigned IDX_W = (MAX_FW_ROM > 1) ? $clog2(MAX_FW_ROM) : 1;

  fw_load_state_t   state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [26:0]      alloc;
  logic [27:0]      src;
  logic [21:0]      len;
  logic [21:0]      cnt;
  logic             armed;

  logic [21:0]      scan_len;
  logic [27:0]      alloc_end;
  logic             scan_load;
  logic             last_idx;
  logic             start;
  logic             rd_issue;
  logic             rd_valid;
  logic [7:0]       rd_data;
  logic             wr_issue;
  logic             wr_done;
  logic             last_byte;
  logic             sram_unused;

  assign scan_len  = 22'(fw_store[idx].block_count) << BLOCK_SHIFT;
  assign alloc_end = {1'b0, alloc} + {6'b0, scan_len};
  // Empty entries and images that would run past the top of slot RAM are skipped.
  assign scan_load = (fw_store[idx].block_count != '0) && (alloc_end <= 28'h8000000);
  assign last_idx  = (idx == IDX_W'(MAX_FW_ROM - 1));
  assign start     = (state == ST_IDLE) && update_request && armed;
  assign wr_issue  = (state == ST_WR_REQ) && ram_ready;
  assign wr_done   = (state == ST_WR_WAIT) && ram_ready && !ram_we;
  assign last_byte = ((cnt + 22'd1) == len);

  assign ddr3_request = (state != ST_IDLE) && (state != ST_DONE);

  // sram_block_count belongs to the SRAM allocator; folded here only so it is read.
  always_comb begin
    sram_unused = 1'b0;
    for (int unsigned i = 0; i < MAX_FW_ROM; i++) begin
      sram_unused = sram_unused ^ (^fw_store[i].sram_block_count);
    end
  end

  ddr3_byte_reader #(
    .ADDR_W (28),
    .DATA_W (8)
  ) u_reader (
    .clk        (clk),
    .reset      (reset),
    .start      (state == ST_RD_REQ),
    .addr       (src + {6'b0, cnt}),
    .issue      (rd_issue),
    .valid      (rd_valid),
    .data       (rd_data),
    .ddr3_addr  (ddr3_addr),
    .ddr3_rd    (ddr3_rd),
    .ddr3_ready (ddr3_ready),
    .ddr3_dout  (ddr3_dout)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. Skipped entries advance straight from SCAN so an empty
  // table costs one cycle per entry; NEXT is only visited after a copy.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (start) state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (scan_load)     state_nxt = ST_RD_REQ;
        else if (last_idx) state_nxt = ST_DONE;
      end
      ST_RD_REQ:  if (rd_issue) state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: if (rd_valid) state_nxt = ST_WR_REQ;
      ST_WR_REQ:  if (ram_ready) state_nxt = ST_WR_WAIT;
      ST_WR_WAIT: if (wr_done) state_nxt = last_byte ? ST_NEXT : ST_RD_REQ;
      ST_NEXT:    state_nxt = last_idx ? ST_DONE : ST_SCAN;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Pass bookkeeping, descriptor capture, RAM write port and published results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      update_ack   <= 1'b0;
      busy         <= 1'b0;
      armed        <= 1'b1;
      idx          <= '0;
      alloc        <= '0;
      src          <= '0;
      len          <= '0;
      cnt          <= '0;
      ram_addr     <= '0;
      ram_din      <= '0;
      ram_we       <= 1'b0;
      fw_ram_valid <= '0;
      for (int unsigned i = 0; i < MAX_FW_ROM; i++) begin
        fw_ram_base[i] <= '0;
      end
    end else begin
      update_ack <= (state == ST_DONE);
      ram_we     <= wr_issue;

      if ((state == ST_IDLE) && !update_request) begin
        armed <= 1'b1;
      end

      if (start) begin
        fw_ram_valid <= '0;
        idx          <= '0;
        alloc        <= RAM_BASE;
        busy         <= 1'b1;
        armed        <= 1'b0;
      end

      if (state == ST_SCAN) begin
        if (scan_load) begin
          src              <= fw_store[idx].store_address;
          len              <= scan_len;
          cnt              <= '0;
          fw_ram_base[idx] <= alloc;
        end else if (!last_idx) begin
          idx <= idx + 1'b1;
        end
      end

      if ((state == ST_RD_WAIT) && rd_valid) begin
        ram_din <= rd_data;
      end

      if (wr_issue) begin
        ram_addr <= alloc + 27'(cnt);
      end

      if (wr_done) begin
        cnt <= cnt + 22'd1;
        if (last_byte) begin
          fw_ram_valid[idx] <= 1'b1;
          alloc             <= alloc + 27'(len);
        end
      end

      if ((state == ST_NEXT) && !last_idx) begin
        idx <= idx + 1'b1;
      end

      if (state == ST_DONE) begin
        busy <= 1'b0;
      end
    end
  end

endmodule
